act_pack: RTL
=============

Name: act_pack

Overview:
- Downstream consumer of the MVM accumulator's (o_valid, o_result) stream.
- Requantizes each finished DATAW-bit dot-product sum: arithmetic right shift with rounding, optional ReLU, saturation to signed OUTW.
- Packs LANES results into one output word and buffers words in a FIFO, because the accumulator has no backpressure.
- Drains to the next layer's input loader over a ready/valid handshake.

Parameters:
- DATAW, 32, width of incoming accumulated sum (signed two's complement)
- OUTW, 8, width of each requantized lane (signed)
- LANES, 4, lanes per packed output word; lane 0 in the LSBs
- FIFO_DEPTH, 16, output FIFO entries; power of two
- FIFO_ADDRW, 4, log2(FIFO_DEPTH)

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- i_valid  input  1  i_result valid this cycle; no backpressure, always accepted
- i_result  input  DATAW  signed accumulated sum
- i_shift  input  5  right-shift amount 0..31; quasi-static, sampled with each i_valid
- i_relu  input  1  1 = clamp negatives to 0; sampled with each i_valid
- i_flush  input  1  emit a partially filled word; pipelined alongside data
- o_valid  output  1  FIFO head is valid
- o_data  output  LANES*OUTW  FIFO head word
- o_keep  output  LANES  per-lane valid mask of the FIFO head
- o_ready  input  1  consumer accepts the head when o_valid && o_ready
- o_overflow  output  1  sticky: a word was dropped because the FIFO was full
- o_count  output  FIFO_ADDRW+1  current FIFO occupancy

Behaviour:
Reset (async assert, release synchronous to clk):
- All pipeline valids, lane counter, packing register, FIFO pointers and count clear to 0.
- o_valid=0, o_data=0, o_keep=0, o_overflow=0, o_count=0.
- Reset mid-word discards partial lanes. No output is produced for data in flight.

Stage S1 (registered):
- s=0: value = i_result.
- s>0: value = (i_result + 2^(s-1)) >>> s, computed in DATAW+1 bits so the rounding add cannot wrap. This is round-half-up toward +inf.
- Valid, relu and flush are registered alongside.

Stage S2 (registered):
- If relu and value<0, value=0.
- Saturate to [-2^(OUTW-1), 2^(OUTW-1)-1], i.e. [-128, 127] at defaults.

Packer (acts on S2 outputs at the next edge):
- lane_cnt counts 0..LANES-1.
- A valid S2 byte is written into lane lane_cnt.
- If lane_cnt==LANES-1, the completed word (keep=all ones) is pushed to the FIFO and lane_cnt returns to 0. Otherwise lane_cnt increments.
- Flush on the same S2 slot as a valid byte: the byte is included first, then the word is pushed with keep = lanes filled and unused lanes zero. lane_cnt returns to 0.
- Flush with lane_cnt==0 and no valid byte: no push.

Latency:
- An element sampled on edge E0 completing a word is in the FIFO after E3; o_valid is high in the cycle after E3.
- Throughput: one element per cycle sustained.

FIFO:
- Show-ahead: o_data and o_keep show the head whenever o_valid=1.
- Pop on o_valid && o_ready. o_ready while empty has no effect.
- Push while count<FIFO_DEPTH: stored.
- Push while full without a same-cycle pop: word dropped, o_overflow set. o_overflow stays set until rst.
- Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
- Push and pop in the same cycle while empty: the word is stored and o_valid rises next cycle. No bypass.
- Pointers wrap modulo FIFO_DEPTH.
- o_count = occupancy after each edge.

Test Plan:
- Shift/round: i_shift=4, i_relu=0, inputs 24, 23, -24, -25 -> one word, lanes 2, 1, -1, -2. o_data=0xFEFF0102, o_keep=0xF, o_valid rises the cycle after E3 of the 4th input.
- Saturation/ReLU: i_shift=0, inputs 1000, -1000 with relu=0 -> lanes 0x7F, 0x80. Same inputs with relu=1 -> lanes 0x7F, 0x00.
- Flush: 2 valid inputs 5, 6 (shift 0), then i_flush alone -> o_data=0x00000605, o_keep=0x3. A second flush with no data -> no push, o_count unchanged.
- Backpressure/overflow: o_ready=0, feed 17*4 inputs -> o_count reaches 16, 17th word dropped, o_overflow=1 and stays 1. Then o_ready=1 -> exactly 16 words drain in order.
- Full simultaneous push/pop: FIFO full, o_ready=1 while a word completes -> o_count stays 16, o_overflow stays 0.
- Async reset: assert rst mid-word with 3 lanes filled and 5 words queued -> outputs go to 0 immediately without waiting for an edge. After release, 4 new inputs -> the first word contains only the new data.

Source files
------------

// File: rtl/act_pack.sv
// act_pack: requantize accumulator sums and pack them into FIFO-buffered words.
//   clk, rst                 clock, async active-high reset
//   i_valid/i_result         accumulated sum stream (no backpressure)
//   i_shift, i_relu          requant controls, sampled with each i_valid
//   i_flush                  emit a partially filled word
//   o_valid/o_data/o_keep    show-ahead FIFO head, lane 0 in the LSBs
//   o_ready                  consumer pops the head when o_valid && o_ready
//   o_overflow               sticky: a word was dropped on a full FIFO
//   o_count                  FIFO occupancy
module act_pack #(
   parameter int DATAW      = 32,
   parameter int OUTW       = 8,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_ADDRW = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_valid,
   input  logic [DATAW-1:0]        i_result,
   input  logic [4:0]              i_shift,
   input  logic                    i_relu,
   input  logic                    i_flush,
   output logic                    o_valid,
   output logic [LANES*OUTW-1:0]   o_data,
   output logic [LANES-1:0]        o_keep,
   input  logic                    o_ready,
   output logic                    o_overflow,
   output logic [FIFO_ADDRW:0]     o_count
);
   localparam int LANEW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int WORDW = LANES*OUTW;
   localparam logic signed [DATAW:0] SAT_MAX = (DATAW+1)'((1 << (OUTW-1)) - 1);
   localparam logic signed [DATAW:0] SAT_MIN = -SAT_MAX - 1;

   // ---------------- S1: rounding arithmetic shift ----------------
   logic signed [DATAW:0] ext, rnd, sum, s1_value_d;
   logic signed [DATAW:0] s1_value_q;
   logic                  s1_valid_q, s1_relu_q, s1_flush_q;

   always_comb begin
      ext = $signed({i_result[DATAW-1], i_result});
      rnd = '0;
      if (i_shift != 5'd0) rnd = (DATAW+1)'(1) << (i_shift - 5'd1);
      // One extra bit keeps the rounding add from wrapping near +max.
      sum        = ext + rnd;
      s1_value_d = sum >>> i_shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_value_q <= '0;
         s1_relu_q  <= 1'b0;
         s1_flush_q <= 1'b0;
      end else begin
         s1_valid_q <= i_valid;
         s1_value_q <= s1_value_d;
         s1_relu_q  <= i_relu;
         s1_flush_q <= i_flush;
      end
   end

   // ---------------- S2: ReLU and saturation ----------------
   logic signed [DATAW:0] relu_v;
   logic [OUTW-1:0]       s2_byte_d, s2_byte_q;
   logic                  s2_valid_q, s2_flush_q;

   always_comb begin
      relu_v = (s1_relu_q && (s1_value_q < 0)) ? '0 : s1_value_q;
      if (relu_v > SAT_MAX)      s2_byte_d = SAT_MAX[OUTW-1:0];
      else if (relu_v < SAT_MIN) s2_byte_d = SAT_MIN[OUTW-1:0];
      else                       s2_byte_d = relu_v[OUTW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_byte_q  <= '0;
         s2_flush_q <= 1'b0;
      end else begin
         s2_valid_q <= s1_valid_q;
         s2_byte_q  <= s2_byte_d;
         s2_flush_q <= s1_flush_q;
      end
   end

   // ---------------- Packer ----------------
   logic [LANEW-1:0] lane_cnt_q;
   logic [WORDW-1:0] pack_q, word_d, push_word_q;
   logic [LANES-1:0] keep_q, keep_d, push_keep_q;
   logic             push_d, push_q;

   always_comb begin
      word_d = pack_q;
      keep_d = keep_q;
      if (s2_valid_q) begin
         word_d[int'(lane_cnt_q)*OUTW +: OUTW] = s2_byte_q;
         keep_d[lane_cnt_q]                    = 1'b1;
      end
      // A flush only pushes when there is at least one lane to emit.
      push_d = (s2_valid_q && (lane_cnt_q == LANEW'(LANES-1))) ||
               (s2_flush_q && (s2_valid_q || (lane_cnt_q != '0)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_cnt_q  <= '0;
         pack_q      <= '0;
         keep_q      <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
         push_keep_q <= '0;
      end else begin
         push_q      <= push_d;
         push_word_q <= word_d;
         push_keep_q <= keep_d;
         if (push_d) begin
            lane_cnt_q <= '0;
            pack_q     <= '0;
            keep_q     <= '0;
         end else if (s2_valid_q) begin
            lane_cnt_q <= lane_cnt_q + 1'b1;
            pack_q     <= word_d;
            keep_q     <= keep_d;
         end
      end
   end

   // ---------------- Output FIFO ----------------
   logic [WORDW-1:0]      mem_data [FIFO_DEPTH];
   logic [LANES-1:0]      mem_keep [FIFO_DEPTH];
   logic [FIFO_ADDRW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_ADDRW:0]   count_q;
   logic                  ovf_q, full, pop, wr;

   always_comb begin
      full = (count_q == (FIFO_ADDRW+1)'(FIFO_DEPTH));
      pop  = (count_q != '0) && o_ready;
      // A full FIFO can still take a word if the head leaves this cycle.
      wr   = push_q && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_data[wr_ptr_q] <= push_word_q;
         mem_keep[wr_ptr_q] <= push_keep_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr && !pop)      count_q <= count_q + 1'b1;
         else if (!wr && pop) count_q <= count_q - 1'b1;
         if (push_q && full && !pop) ovf_q <= 1'b1;
      end
   end

   // Head is gated so the outputs read zero while empty and during reset.
   assign o_valid    = (count_q != '0);
   assign o_data     = o_valid ? mem_data[rd_ptr_q] : '0;
   assign o_keep     = o_valid ? mem_keep[rd_ptr_q] : '0;
   assign o_overflow = ovf_q;
   assign o_count    = count_q;
endmodule
